pic16_stack: RTL
================

PIC16_STACK -- requirements
Module: pic16_stack

Interface
REQ-001 Parameter AW, default 13: width of each stack entry in bits (program-counter width).
REQ-002 Parameter DEPTH, default 8: number of entries; SHALL be a power of two, at least 2.
REQ-003 Parameter MODE, default 0: 0 = circular (wrap and overwrite), 1 = protected (ignore illegal operations).
REQ-004 Port CLK, input, 1: single clock; all state changes on posedge CLK.
REQ-005 Port nRST, input, 1: reset, asynchronous, active-low.
REQ-006 Port PUSH, input, 1: push DIN (CALL).
REQ-007 Port POP, input, 1: pop top entry (RETURN, RETLW, RETFIE).
REQ-008 Port FLUSH, input, 1: synchronous empty of the stack.
REQ-009 Port CLR_ERR, input, 1: synchronous clear of the OVF and UNF flags.
REQ-010 Port DIN, input, AW: return address to push.
REQ-011 Port TOP, output, AW: entry at index (SP-1) mod DEPTH.
REQ-012 Port CNT, output, log2(DEPTH)+1: number of valid entries, 0..DEPTH.
REQ-013 Port EMPTY, output, 1: asserted when CNT == 0.
REQ-014 Port FULL, output, 1: asserted when CNT == DEPTH.
REQ-015 Port OVF, output, 1: sticky flag, push attempted while full.
REQ-016 Port UNF, output, 1: sticky flag, pop attempted while empty.

Function
REQ-017 Internal state: entry array STK[0..DEPTH-1] of AW bits; pointer SP of log2(DEPTH) bits (next free slot); CNT; OVF; UNF.
REQ-018 TOP, EMPTY and FULL SHALL be combinational from state; a pushed value appears on TOP in the cycle after the push edge (1-cycle latency).
REQ-019 Priority, per cycle: FLUSH > (PUSH and POP) > PUSH > POP.
REQ-020 FLUSH: SP=0, CNT=0; flags unchanged; PUSH and POP ignored that cycle.
REQ-021 PUSH only, not full: STK[SP]=DIN, SP=SP+1 mod DEPTH, CNT+1.
REQ-022 PUSH only, full, MODE 0: STK[SP]=DIN, SP+1 (overwrites oldest), CNT stays DEPTH, OVF=1.
REQ-023 PUSH only, full, MODE 1: no write, SP and CNT unchanged, OVF=1.
REQ-024 POP only, not empty: SP=SP-1 mod DEPTH, CNT-1.
REQ-025 POP only, empty, MODE 0: SP=SP-1 mod DEPTH (wrap), CNT stays 0, UNF=1.
REQ-026 POP only, empty, MODE 1: SP and CNT unchanged, UNF=1.
REQ-027 PUSH and POP together, not empty: STK[(SP-1) mod DEPTH]=DIN (replace top); SP and CNT unchanged; no flag change.
REQ-028 PUSH and POP together, empty: behaves as PUSH only (REQ-021); UNF not set.
REQ-029 CLR_ERR clears OVF and UNF; a flag-setting event in the same cycle wins (flag reads 1 afterwards).
REQ-030 SP arithmetic is modulo DEPTH by natural overflow; CNT never exceeds DEPTH and never goes below 0.
REQ-031 While EMPTY, TOP is don't-care; the bench SHALL NOT check it.

Reset
REQ-032 nRST low SHALL, immediately and independent of CLK: SP=0, CNT=0, OVF=0, UNF=0; EMPTY=1, FULL=0.
REQ-033 STK contents are not reset.
REQ-034 nRST deasserted mid-sequence: first active edge after release operates on reset state; any operation in progress before reset is lost.

Verification
REQ-035 MODE 0, DEPTH 8: push 0x0001..0x0008, then pop 8 times -> TOP reads 0x0008 down to 0x0001; CNT 8 -> 0; EMPTY=1 at end; OVF=0, UNF=0.
REQ-036 MODE 0: push 0x0001..0x0009 -> OVF=1, CNT=8, TOP=0x0009; 8 pops -> TOP sequence 0x0009..0x0002.
REQ-037 MODE 1: 9 pushes (0x0001..0x0009) -> OVF=1, CNT=8, TOP=0x0008; then a pop with CLR_ERR high -> OVF=0, CNT=7, TOP=0x0007.
REQ-038 After 2 pushes (0x0100, 0x0200), PUSH and POP together with DIN=0x0ABC -> TOP=0x0ABC, CNT=2; next pop -> TOP=0x0100.
REQ-039 Empty, POP in MODE 0 -> UNF=1, CNT=0, SP=7; POP together with CLR_ERR -> UNF stays 1; CLR_ERR alone -> UNF=0.
REQ-040 After 3 pushes, assert nRST between clock edges -> CNT=0, EMPTY=1, flags 0 before the next edge; FLUSH with PUSH high -> CNT=0.

Source files
------------

// File: rtl/pic16_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : pic16_stack_if
// Description : Control and status bundle of the PIC16-style hardware return
//               stack.
//               master : the sequencer that issues CALL/RETURN operations.
//               slave  : the stack itself.
//               Command signals : PUSH, POP, FLUSH, CLR_ERR, DIN[AW-1:0]
//               Status signals  : TOP[AW-1:0], CNT[log2(DEPTH):0], EMPTY,
//                                 FULL, OVF, UNF
// Revision    : 1.0 - initial release
// ============================================================================
interface pic16_stack_if #(
    parameter int AW    = 13,
    parameter int DEPTH = 8
);
    localparam int c_CW = $clog2(DEPTH) + 1;

    logic            PUSH;
    logic            POP;
    logic            FLUSH;
    logic            CLR_ERR;
    logic [AW-1:0]   DIN;
    logic [AW-1:0]   TOP;
    logic [c_CW-1:0] CNT;
    logic            EMPTY;
    logic            FULL;
    logic            OVF;
    logic            UNF;

    modport master (
        output PUSH, POP, FLUSH, CLR_ERR, DIN,
        input  TOP, CNT, EMPTY, FULL, OVF, UNF
    );

    modport slave (
        input  PUSH, POP, FLUSH, CLR_ERR, DIN,
        output TOP, CNT, EMPTY, FULL, OVF, UNF
    );
endinterface
`default_nettype wire

// File: rtl/pic16_stack.sv
`default_nettype none
// ============================================================================
// Module      : pic16_stack
// Description : PIC16-style hardware return-address stack.
//               DEPTH entries of AW bits, a wrapping next-free pointer, an
//               occupancy count and sticky overflow/underflow flags.
//               MODE 0 : circular - push on full overwrites the oldest entry,
//                        pop on empty still moves the pointer.
//               MODE 1 : protected - illegal operations leave the stack alone.
// Ports       : CLK   - clock, all state changes on its rising edge
//               nRST  - asynchronous active-low reset
//               bus   - pic16_stack_if.slave (commands in, status out)
// Revision    : 1.0 - initial release
// ============================================================================
module pic16_stack #(
    parameter int AW    = 13,
    parameter int DEPTH = 8,
    parameter int MODE  = 0
) (
    input  wire logic         CLK,
    input  wire logic         nRST,
    pic16_stack_if.slave      bus
);
    localparam int               c_PW       = $clog2(DEPTH);
    localparam logic [c_PW:0]    c_CNT_FULL = (c_PW + 1)'(DEPTH);
    localparam logic [c_PW-1:0]  c_SP_ONE   = c_PW'(1);
    localparam logic [c_PW:0]    c_CNT_ONE  = (c_PW + 1)'(1);

    // Entry storage is deliberately left out of reset: only the pointer and
    // count define which entries are meaningful.
    logic [AW-1:0]   r_stk [DEPTH];
    logic [c_PW-1:0] r_sp;
    logic [c_PW:0]   r_cnt;
    logic            r_ovf;
    logic            r_unf;

    logic            w_empty;
    logic            w_full;
    logic [c_PW-1:0] w_top_idx;
    logic            w_we;
    logic [c_PW-1:0] w_waddr;
    logic [c_PW-1:0] w_sp_nxt;
    logic [c_PW:0]   w_cnt_nxt;
    logic            w_set_ovf;
    logic            w_set_unf;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == c_CNT_FULL);
    // Pointer arithmetic wraps naturally at the power-of-two depth.
    assign w_top_idx = r_sp - c_SP_ONE;

    // ------------------------------------------------------------------
    // Next-state decode. Priority: FLUSH, then combined PUSH+POP, then
    // PUSH alone, then POP alone.
    // ------------------------------------------------------------------
    always_comb begin
        w_we      = 1'b0;
        w_waddr   = r_sp;
        w_sp_nxt  = r_sp;
        w_cnt_nxt = r_cnt;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;

        if (bus.FLUSH) begin
            w_sp_nxt  = '0;
            w_cnt_nxt = '0;
        end else if (bus.PUSH && bus.POP && !w_empty) begin
            // Replace the top entry in place (e.g. RETURN followed by CALL).
            w_we    = 1'b1;
            w_waddr = w_top_idx;
        end else if (bus.PUSH) begin
            // A combined PUSH+POP on an empty stack also lands here: an empty
            // stack can never be full, so it is a plain push with no UNF.
            if (!w_full) begin
                w_we      = 1'b1;
                w_sp_nxt  = r_sp + c_SP_ONE;
                w_cnt_nxt = r_cnt + c_CNT_ONE;
            end else begin
                w_set_ovf = 1'b1;
                if (MODE == 0) begin
                    // Slot SP holds the oldest entry when full.
                    w_we     = 1'b1;
                    w_sp_nxt = r_sp + c_SP_ONE;
                end
            end
        end else if (bus.POP) begin
            if (!w_empty) begin
                w_sp_nxt  = w_top_idx;
                w_cnt_nxt = r_cnt - c_CNT_ONE;
            end else begin
                w_set_unf = 1'b1;
                if (MODE == 0) begin
                    w_sp_nxt = w_top_idx;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointer, count and sticky flags. A flag-setting event beats CLR_ERR
    // in the same cycle so that no error is ever silently lost.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_sp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_sp  <= w_sp_nxt;
            r_cnt <= w_cnt_nxt;

            if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end else if (bus.CLR_ERR) begin
                r_ovf <= 1'b0;
            end

            if (w_set_unf) begin
                r_unf <= 1'b1;
            end else if (bus.CLR_ERR) begin
                r_unf <= 1'b0;
            end
        end
    end

    // Entry array: write port only, no reset.
    always_ff @(posedge CLK) begin
        if (w_we) begin
            r_stk[w_waddr] <= bus.DIN;
        end
    end

    assign bus.TOP   = r_stk[w_top_idx];
    assign bus.CNT   = r_cnt;
    assign bus.EMPTY = w_empty;
    assign bus.FULL  = w_full;
    assign bus.OVF   = r_ovf;
    assign bus.UNF   = r_unf;

endmodule
`default_nettype wire
